// File: rtl/idx_loop_ctrl.sv
// Loop controller for the X index register pair (i / iref): loads the limit and the
// start index, then walks i by a stride and hands each index to the datapath.
module idx_loop_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] stride,
  input  logic             step,
  output logic [WIDTH-1:0] idx,
  output logic             idx_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             write_i,
  output logic             write_iref,
  output logic             read_i,
  output logic             read_iref,
  output logic [WIDTH-1:0] reg_wdata,
  input  logic [WIDTH-1:0] reg_rdata,
  input  logic             iflag
);

  localparam int             ITW      = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);
  localparam logic [ITW-1:0] ITER_MAX = ITW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_REF = 3'd1,
    S_LD_I   = 3'd2,
    S_CHECK  = 3'd3,
    S_READ   = 3'd4,
    S_READY  = 3'd5,
    S_INC    = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] stride_q, stride_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [ITW-1:0]   iter_q, iter_d;
  logic             idx_valid_q, idx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             write_i_q, write_i_d;
  logic             write_iref_q, write_iref_d;
  logic             read_i_q, read_i_d;
  logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] nxt_s;

  // Next index with one extra bit so a wrap is caught and clamped to the limit,
  // which guarantees the register eventually raises iflag.
  always_comb begin
    sum_s = {1'b0, idx_q} + {1'b0, stride_q};
    if (sum_s[WIDTH] || (sum_s[WIDTH-1:0] > limit_q)) begin
      nxt_s = limit_q;
    end else begin
      nxt_s = sum_s[WIDTH-1:0];
    end
  end

  // Loop sequencing; outputs are decoded from the next state and registered.
  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    init_d   = init_q;
    stride_d = stride_q;
    iter_d   = iter_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d  = limit;
          init_d   = init;
          stride_d = (stride == {WIDTH{1'b0}}) ? WIDTH'(1) : stride;
          iter_d   = {ITW{1'b0}};
          if (init > limit) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_LD_REF;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_REF: state_d = S_LD_I;
      S_LD_I:   state_d = S_CHECK;
      S_CHECK: begin
        if (iflag) begin
          state_d = S_DONE;
        end else if (iter_q == ITER_MAX) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_READY;
      S_READY: begin
        if (step) begin
          state_d = S_INC;
          iter_d  = iter_q + ITW'(1);
        end else begin
          state_d = S_READY;
        end
      end
      S_INC:   state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      iter_d  = iter_q;
    end else begin
      iter_d  = iter_d;
    end

    if (state_q == S_READ) begin
      idx_d = reg_rdata;
    end else begin
      idx_d = idx_q;
    end

    idx_valid_d  = (state_d == S_READY);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    write_iref_d = (state_d == S_LD_REF);
    write_i_d    = (state_d == S_LD_I) || (state_d == S_INC);
    read_i_d     = (state_d == S_READ);

    case (state_d)
      S_LD_REF: reg_wdata_d = limit_d;
      S_LD_I:   reg_wdata_d = init_q;
      S_INC:    reg_wdata_d = nxt_s;
      default:  reg_wdata_d = {WIDTH{1'b0}};
    endcase
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      limit_q      <= {WIDTH{1'b0}};
      init_q       <= {WIDTH{1'b0}};
      stride_q     <= {WIDTH{1'b0}};
      idx_q        <= {WIDTH{1'b0}};
      iter_q       <= {ITW{1'b0}};
      idx_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      write_i_q    <= 1'b0;
      write_iref_q <= 1'b0;
      read_i_q     <= 1'b0;
      reg_wdata_q  <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      init_q       <= init_d;
      stride_q     <= stride_d;
      idx_q        <= idx_d;
      iter_q       <= iter_d;
      idx_valid_q  <= idx_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      write_i_q    <= write_i_d;
      write_iref_q <= write_iref_d;
      read_i_q     <= read_i_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign write_i    = write_i_q;
  assign write_iref = write_iref_q;
  assign read_i     = read_i_q;
  assign read_iref  = 1'b0;
  assign reg_wdata  = reg_wdata_q;

endmodule

// File: tb/tb_idx_loop_ctrl.sv
// Bench for idx_loop_ctrl: index sequence, strobe data and timing are compared
// against a list-based model of the loop; a second instance exercises the watchdog.
module tb_idx_loop_ctrl;

  logic        clk, rst_n, start, abort, step;
  logic [15:0] limit, init, stride;
  logic [15:0] idx, reg_wdata, reg_rdata;
  logic        idx_valid, busy, done, err, write_i, write_iref, read_i, read_iref, iflag;
  logic [15:0] idx2, reg_wdata2, reg_rdata2;
  logic        idx_valid2, busy2, done2, err2, write_i2, write_iref2, read_i2, read_iref2;
  logic [15:0] i_m, iref_m, i2_m;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  idx_loop_ctrl #(.WIDTH(16), .MAX_ITER(65535)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .limit(limit), .init(init),
    .stride(stride), .step(step), .idx(idx), .idx_valid(idx_valid), .busy(busy), .done(done),
    .err(err), .write_i(write_i), .write_iref(write_iref), .read_i(read_i),
    .read_iref(read_iref), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .iflag(iflag));

  idx_loop_ctrl #(.WIDTH(16), .MAX_ITER(3)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .limit(limit), .init(init),
    .stride(stride), .step(step), .idx(idx2), .idx_valid(idx_valid2), .busy(busy2), .done(done2),
    .err(err2), .write_i(write_i2), .write_iref(write_iref2), .read_i(read_i2),
    .read_iref(read_iref2), .reg_wdata(reg_wdata2), .reg_rdata(reg_rdata2), .iflag(1'b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Reg_X: i/iref written on strobes, flag compares them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_m <= 16'd0; iref_m <= 16'd0; i2_m <= 16'd0;
    end else begin
      if (write_i)    i_m    <= reg_wdata;
      if (write_iref) iref_m <= reg_wdata;
      if (write_i2)   i2_m   <= reg_wdata2;
    end
  end
  assign iflag      = (i_m == iref_m);
  assign reg_rdata  = read_i  ? i_m  : 16'd0;
  assign reg_rdata2 = read_i2 ? i2_m : 16'd0;

  task automatic do_reset;
    start = 1'b0; step = 1'b0; abort = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!idx_valid && n < 100) begin @(posedge clk); #1; n++; end
    ok = idx_valid;
  endtask

  // One complete loop compared against the expected index list and write list.
  task automatic run_loop(input int lim, input int ini, input int str, input string nm);
    int exp_q[$]; int wexp[$];
    int s, v, cyc, last_evt, got, wcnt, refcnt, rdcnt, wait_cnt, exp_done;
    bit exp_err, prev_valid, fin;
    s = (str == 0) ? 1 : str;
    exp_err = (ini > lim);
    if (!exp_err) begin
      wexp.push_back(ini);
      v = ini;
      while (v < lim) begin
        exp_q.push_back(v);
        wexp.push_back((v + s > lim) ? lim : v + s);
        v = v + s;
      end
    end
    limit = 16'(lim); init = 16'(ini); stride = 16'(str); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1; last_evt = 0; got = 0; wcnt = 0; refcnt = 0; rdcnt = 0;
    wait_cnt = 0; prev_valid = 1'b0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (write_iref) begin
        total_cnt++;
        if (reg_wdata !== 16'(lim)) $display("FAIL %s iref_data: got %0d want %0d", nm, reg_wdata, lim);
        else pass_cnt++;
        refcnt++;
      end
      if (write_i) begin
        total_cnt++;
        if (wcnt >= wexp.size()) $display("FAIL %s i_write_extra: got %0d want none", nm, reg_wdata);
        else if (reg_wdata !== 16'(wexp[wcnt])) $display("FAIL %s i_data: got %0d want %0d", nm, reg_wdata, wexp[wcnt]);
        else pass_cnt++;
        wcnt++;
      end
      if (read_i) rdcnt++;
      if (idx_valid && !prev_valid) begin
        total_cnt++;
        if (got >= exp_q.size()) $display("FAIL %s idx_extra: got %0d want none", nm, idx);
        else if (idx !== 16'(exp_q[got])) $display("FAIL %s idx: got %0d want %0d", nm, idx, exp_q[got]);
        else pass_cnt++;
        total_cnt++;
        if (cyc - last_evt != ((got == 0) ? 5 : 4))
          $display("FAIL %s latency: got %0d want %0d", nm, cyc - last_evt, (got == 0) ? 5 : 4);
        else pass_cnt++;
        got++;
        wait_cnt = $urandom_range(0, 2);
      end
      prev_valid = idx_valid;
      if (idx_valid) begin
        if (wait_cnt == 0) begin step = 1'b1; last_evt = cyc; end
        else wait_cnt--;
      end
      if (done) begin
        fin = 1'b1;
        exp_done = exp_err ? 1 : ((exp_q.size() == 0) ? 4 : last_evt + 3);
        total_cnt++;
        if (err !== exp_err) $display("FAIL %s err: got %0b want %0b", nm, err, exp_err); else pass_cnt++;
        total_cnt++;
        if (cyc != exp_done) $display("FAIL %s done_time: got %0d want %0d", nm, cyc, exp_done); else pass_cnt++;
        total_cnt++;
        if (got != exp_q.size() || rdcnt != exp_q.size())
          $display("FAIL %s episodes: got %0d/%0d want %0d", nm, got, rdcnt, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (wcnt != wexp.size() || refcnt != (exp_err ? 0 : 1))
          $display("FAIL %s write_count: got %0d/%0d want %0d/%0d", nm, wcnt, refcnt, wexp.size(), exp_err ? 0 : 1);
        else pass_cnt++;
      end
      @(posedge clk); #1; step = 1'b0; cyc++;
    end
    total_cnt++;
    if (!fin) $display("FAIL %s timeout: got no done want done", nm);
    else if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s idle_after: got done=%0b busy=%0b want 0 0", nm, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0;
    limit = 16'd0; init = 16'd0; stride = 16'd0;
    @(posedge clk); #1;
    total_cnt++;
    if ({idx_valid, busy, done, err, write_i, write_iref, read_i, read_iref, reg_wdata, idx} !== 40'd0)
      $display("FAIL reset_outputs: got busy=%0b wdata=%0d idx=%0d want all 0", busy, reg_wdata, idx);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, busy2, done2} !== 4'd0) $display("FAIL reset_idle: got busy=%0b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    run_loop(5, 0, 1, "lim5_init0");
    run_loop(10, 1, 4, "lim10_s4");
    run_loop(7, 7, 3, "init_eq_lim");
    run_loop(3, 9, 2, "init_gt_lim");
    run_loop(16'hFFF0, 16'hFFE0, 16'h8000, "carry_clamp");
  endtask

  task automatic test_random;
    for (int t = 0; t < 10; t++)
      run_loop($urandom_range(0, 40), $urandom_range(0, 44), $urandom_range(0, 7), "random");
  endtask

  task automatic test_abort;
    bit ok, bad;
    do_reset;
    limit = 16'd10; init = 16'd0; stride = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 2; k++) begin wait_valid(ok); step = 1'b1; @(posedge clk); #1; step = 1'b0; end
    wait_valid(ok);
    total_cnt++;
    if (!ok || idx !== 16'd2) $display("FAIL abort_idx: got %0d want 2", idx); else pass_cnt++;
    abort = 1'b1; step = 1'b1;
    @(posedge clk); #1; abort = 1'b0; step = 1'b0;
    total_cnt++;
    if ({busy, idx_valid, write_i, done, err} !== 5'd0)
      $display("FAIL abort_next: got busy=%0b valid=%0b wr=%0b done=%0b want 0", busy, idx_valid, write_i, done);
    else pass_cnt++;
    bad = 1'b0;
    for (int j = 0; j < 6; j++) begin @(posedge clk); #1; if (write_i || done || err || busy) bad = 1'b1; end
    total_cnt++;
    if (bad) $display("FAIL abort_quiet: got activity want none"); else pass_cnt++;
    run_loop(4, 1, 0, "after_abort");
  endtask

  task automatic test_reset_mid_loop;
    bit ok;
    do_reset;
    limit = 16'd5; init = 16'd0; stride = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_valid(ok);
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    total_cnt++;
    if (write_i !== 1'b1 || reg_wdata !== 16'd1) $display("FAIL inc_write: got %0b/%0d want 1/1", write_i, reg_wdata);
    else pass_cnt++;
    rst_n = 1'b0; #1;
    total_cnt++;
    if ({idx_valid, busy, done, err, write_i, write_iref, read_i, read_iref, reg_wdata, idx} !== 40'd0)
      $display("FAIL async_reset: got wr=%0b busy=%0b wdata=%0d want all 0", write_i, busy, reg_wdata);
    else pass_cnt++;
    #2; rst_n = 1'b1;
    run_loop(5, 0, 1, "post_reset");
  endtask

  task automatic test_watchdog;
    int got_q[$]; int n; bit fin, pv, errv;
    do_reset;
    limit = 16'd100; init = 16'd0; stride = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0; fin = 1'b0; pv = 1'b0; errv = 1'b0;
    while (!fin && n < 300) begin
      if (idx_valid2 && !pv) got_q.push_back(int'(idx2));
      pv = idx_valid2;
      if (idx_valid2) step = 1'b1;
      if (done2) begin fin = 1'b1; errv = err2; end
      @(posedge clk); #1; step = 1'b0; n++;
    end
    total_cnt++;
    if (!fin || errv !== 1'b1) $display("FAIL watchdog_err: got done=%0b err=%0b want 1 1", fin, errv); else pass_cnt++;
    total_cnt++;
    if (got_q.size() != 3) $display("FAIL watchdog_count: got %0d want 3", got_q.size()); else pass_cnt++;
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      total_cnt++;
      if (got_q[k] != k) $display("FAIL watchdog_idx: got %0d want %0d", got_q[k], k); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_reset_mid_loop;
    test_watchdog;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
